// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_pkg;

    typedef enum logic [1:0] {StIdle, StOpenIn, StOpenOut, StSettle} state_t;

    localparam int unsigned SETTLE_LEN = 4;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
    localparam logic [6:0] SEG_PATTERN [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

endpackage

// File: rtl/parking_gate_ctrl_seg7_decode.sv
// Combinational 4-bit value to active-low 7-segment pattern; out-of-range values blank.
module seg7_decode
    import parking_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (value)
            4'd0:    seg = SEG_PATTERN[0];
            4'd1:    seg = SEG_PATTERN[1];
            4'd2:    seg = SEG_PATTERN[2];
            4'd3:    seg = SEG_PATTERN[3];
            4'd4:    seg = SEG_PATTERN[4];
            4'd5:    seg = SEG_PATTERN[5];
            4'd6:    seg = SEG_PATTERN[6];
            4'd7:    seg = SEG_PATTERN[7];
            4'd8:    seg = SEG_PATTERN[8];
            4'd9:    seg = SEG_PATTERN[9];
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: entry/exit FSM, occupancy counter and two-digit scanned display.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY     = 8,
    parameter int unsigned GATE_TIMEOUT = 1000,
    parameter int unsigned SCAN_DIV     = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       pass_done,
    output logic       gate_open,
    output logic       gate_dir,
    output logic       reject,
    output logic [3:0] occupancy,
    output logic       full,
    output logic       empty,
    output logic [6:0] seg,
    output logic [7:0] AN
);

    localparam int unsigned TW = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0]    CAP          = 4'(CAPACITY);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(GATE_TIMEOUT - 1);
    localparam logic [SW-1:0] SCAN_LAST    = SW'(SCAN_DIV - 1);
    localparam logic [1:0]    SETTLE_LAST  = 2'(SETTLE_LEN - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic [1:0]    settle_cnt;
    logic [3:0]    holdoff;
    logic          take_exit;
    logic          take_entry;
    logic          refused;

    assign full       = (occupancy == CAP);
    assign empty      = (occupancy == 4'd0);
    assign take_exit  = exit_req && !empty;
    assign take_entry = entry_req && !take_exit && !full;
    assign refused    = (entry_req && full) || (exit_req && empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            gate_open  <= 1'b0;
            gate_dir   <= 1'b0;
            reject     <= 1'b0;
            occupancy  <= 4'd0;
            timer      <= '0;
            settle_cnt <= 2'd0;
            holdoff    <= 4'd0;
        end else begin
            reject <= 1'b0;
            if (holdoff != 4'd0) holdoff <= holdoff - 4'd1;
            // A fresh request after both lines drop may be refused immediately.
            if (!entry_req && !exit_req) holdoff <= 4'd0;
            unique case (state)
                StIdle: begin
                    timer      <= '0;
                    settle_cnt <= 2'd0;
                    if (take_exit) begin
                        state     <= StOpenOut;
                        gate_open <= 1'b1;
                        gate_dir  <= 1'b0;
                    end else if (take_entry) begin
                        state     <= StOpenIn;
                        gate_open <= 1'b1;
                        gate_dir  <= 1'b1;
                    end else if (refused && holdoff == 4'd0) begin
                        reject  <= 1'b1;
                        holdoff <= 4'd15;
                    end
                end
                StOpenIn, StOpenOut: begin
                    if (pass_done) begin
                        if (state == StOpenIn && occupancy != CAP) begin
                            occupancy <= occupancy + 4'd1;
                        end else if (state == StOpenOut && occupancy != 4'd0) begin
                            occupancy <= occupancy - 4'd1;
                        end
                        state     <= StSettle;
                        gate_open <= 1'b0;
                    end else if (timer == TIMEOUT_LAST) begin
                        state     <= StSettle;
                        gate_open <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                StSettle: begin
                    if (settle_cnt == SETTLE_LAST) state <= StIdle;
                    else settle_cnt <= settle_cnt + 2'd1;
                end
                default: state <= StIdle;
            endcase
        end
    end

    logic [SW-1:0] scan_cnt;
    logic          slot;
    logic          slot_next;
    logic [3:0]    shown;
    logic [6:0]    seg_next;

    always_comb begin
        slot_next = slot;
        if (scan_cnt == SCAN_LAST) slot_next = ~slot;
        shown = slot_next ? (CAP - occupancy) : occupancy;
    end

    seg7_decode u_seg7_decode (
        .value (shown),
        .seg   (seg_next)
    );

    // AN and seg are both derived from slot_next so they switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            slot     <= 1'b0;
            AN       <= 8'b11111110;
            seg      <= SEG_PATTERN[0];
        end else begin
            scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SW'(1);
            slot     <= slot_next;
            AN       <= slot_next ? 8'b11111101 : 8'b11111110;
            seg      <= seg_next;
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench: directed scenarios plus randomized entry/exit traffic against a count model.
module tb_parking_gate_ctrl;

    localparam int CAP  = 8;
    localparam int TMO  = 10;
    localparam int SCAN = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       pass_done = 1'b0;
    logic       gate_open;
    logic       gate_dir;
    logic       reject;
    logic [3:0] occupancy;
    logic       full;
    logic       empty;
    logic [6:0] seg;
    logic [7:0] AN;

    int total = 0;
    int bad = 0;
    int m_occ = 0;

    parking_gate_ctrl #(
        .CAPACITY     (CAP),
        .GATE_TIMEOUT (TMO),
        .SCAN_DIV     (SCAN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .entry_req (entry_req),
        .exit_req  (exit_req),
        .pass_done (pass_done),
        .gate_open (gate_open),
        .gate_dir  (gate_dir),
        .reject    (reject),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty),
        .seg       (seg),
        .AN        (AN)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] pat(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags();
        chk("occupancy", occupancy, m_occ);
        chk("full", full, (m_occ == CAP));
        chk("empty", empty, (m_occ == 0));
    endtask

    task automatic settle_wait();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("settle_closed", gate_open, 0);
        end
    endtask

    // One request; pass_delay < 0 lets the gate time out.
    task automatic op(input bit is_exit, input int pass_delay);
        bit ok;
        int n;
        ok = is_exit ? (m_occ > 0) : (m_occ < CAP);
        if (is_exit) exit_req = 1'b1;
        else entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        exit_req = 1'b0;
        if (!ok) begin
            chk("reject_on", reject, 1);
            chk("reject_gate", gate_open, 0);
            tick();
            chk("reject_single", reject, 0);
            chk_flags();
            return;
        end
        chk("gate_open", gate_open, 1);
        chk("gate_dir", gate_dir, is_exit ? 0 : 1);
        if (pass_delay < 0) begin
            n = 1;
            for (int i = 0; i < TMO + 5; i++) begin
                tick();
                if (gate_open !== 1'b1) break;
                n++;
            end
            chk("timeout_len", n, TMO);
            chk_flags();
        end else begin
            repeat (pass_delay) tick();
            pass_done = 1'b1;
            tick();
            pass_done = 1'b0;
            m_occ = is_exit ? m_occ - 1 : m_occ + 1;
            chk("pass_close", gate_open, 0);
            chk_flags();
        end
        settle_wait();
    endtask

    task automatic chk_display();
        bit seen0 = 1'b0;
        bit seen1 = 1'b0;
        for (int i = 0; i < 2 * SCAN + 4 && !(seen0 && seen1); i++) begin
            tick();
            if (AN === 8'b11111110 && !seen0) begin
                seen0 = 1'b1;
                chk("seg_slot0", seg, pat(m_occ));
            end else if (AN === 8'b11111101 && !seen1) begin
                seen1 = 1'b1;
                chk("seg_slot1", seg, pat(CAP - m_occ));
            end
        end
        chk("slots_seen", {seen0, seen1}, 2'b11);
    endtask

    initial begin
        int rej_n;
        int last_rej;
        int min_gap;
        int open_cycles;
        int d;

        // Reset state
        repeat (2) tick();
        chk("rst_gate", gate_open, 0);
        chk("rst_dir", gate_dir, 0);
        chk("rst_reject", reject, 0);
        chk("rst_an", AN, 8'b11111110);
        chk("rst_seg", seg, 7'b1000000);
        chk_flags();
        rst = 1'b0;
        tick();

        // Exit while empty is refused
        op(1'b1, 0);

        // Stray pass_done while idle is ignored
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        tick();
        chk("idle_pass_ignored", occupancy, 0);

        // Fill to capacity
        for (int i = 0; i < CAP; i++) op(1'b0, $urandom_range(0, 5));
        chk("fill_full", full, 1);
        chk_display();

        // Entry held while full: rate-limited rejects, gate never moves
        rej_n = 0;
        last_rej = -100;
        min_gap = 1000;
        open_cycles = 0;
        entry_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (gate_open === 1'b1) open_cycles++;
            if (reject === 1'b1) begin
                if (c - last_rej < min_gap) min_gap = c - last_rej;
                last_rej = c;
                rej_n++;
            end
        end
        entry_req = 1'b0;
        tick();
        chk("full_no_open", open_cycles, 0);
        chk("full_rej_count", rej_n, 3);
        chk("full_rej_gap", (min_gap >= 16), 1);
        chk_flags();

        // Randomized traffic; delay 7 means let the gate time out
        for (int i = 0; i < 24; i++) begin
            d = $urandom_range(0, 7);
            op(1'($urandom_range(0, 1)), (d == 7) ? -1 : d);
        end
        chk_display();
        while (m_occ > 3) op(1'b1, 1);
        while (m_occ < 3) op(1'b0, 1);

        // Simultaneous requests: exit wins, entry waits out SETTLE
        entry_req = 1'b1;
        exit_req = 1'b1;
        tick();
        exit_req = 1'b0;
        chk("simul_open", gate_open, 1);
        chk("simul_dir", gate_dir, 0);
        tick();
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        m_occ = 2;
        chk("simul_occ", occupancy, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("simul_settle_gate", gate_open, 0);
            chk("simul_settle_rej", reject, 0);
        end
        tick();
        entry_req = 1'b0;
        chk("simul_entry_open", gate_open, 1);
        chk("simul_entry_dir", gate_dir, 1);
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        m_occ = 3;
        chk_flags();
        settle_wait();

        // Timeout with no pass_done
        op(1'b0, -1);

        // Reset mid-pass discards the pending increment
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        chk("midpass_open", gate_open, 1);
        tick();
        rst = 1'b1;
        pass_done = 1'b1;
        tick();
        rst = 1'b0;
        pass_done = 1'b0;
        m_occ = 0;
        chk("midpass_gate", gate_open, 0);
        chk("midpass_an", AN, 8'b11111110);
        chk("midpass_seg", seg, 7'b1000000);
        chk_flags();
        tick();
        op(1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter CAPACITY, default 8: number of parking spaces; legal range 1..9.
REQ-002 Parameter GATE_TIMEOUT, default 1000: maximum cycles the gate stays open without pass_done.
REQ-003 Parameter SCAN_DIV, default 5000: cycles per display digit slot.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 entry_req  input  1  car waiting at the entry sensor; level, held high until served.
REQ-007 exit_req  input  1  car waiting at the exit sensor; level, held high until served.
REQ-008 pass_done  input  1  single-cycle pulse: the car has cleared the gate.
REQ-009 gate_open  output  1  gate actuator; 1 = open.
REQ-010 gate_dir  output  1  direction of the current pass: 1 = entry, 0 = exit; valid only while gate_open = 1.
REQ-011 reject  output  1  single-cycle pulse: a request was refused (entry when full, exit when empty).
REQ-012 occupancy  output  4  current car count, 0..CAPACITY.
REQ-013 full  output  1  occupancy == CAPACITY.
REQ-014 empty  output  1  occupancy == 0.
REQ-015 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-016 AN  output  8  active-low digit enables.

Function
REQ-017 FSM states: IDLE, OPEN_IN, OPEN_OUT, SETTLE.
REQ-018 IDLE, exit_req=1 and empty=0 -> OPEN_OUT, gate_open=1 on the next cycle; exit wins over simultaneous entry_req.
REQ-019 IDLE, entry_req=1, exit not taken, full=0 -> OPEN_IN, gate_open=1 on the next cycle.
REQ-020 IDLE, entry_req=1 with full=1, or exit_req=1 with empty=1 (request not taken) -> reject=1 for one cycle; FSM stays IDLE; at most one reject per 16 cycles while the request stays high.
REQ-021 OPEN_IN or OPEN_OUT, pass_done=1 -> occupancy +1 (OPEN_IN) or -1 (OPEN_OUT) in the same edge; go to SETTLE.
REQ-022 OPEN_* with GATE_TIMEOUT cycles elapsed and no pass_done -> SETTLE; occupancy unchanged.
REQ-023 pass_done outside OPEN_* is ignored.
REQ-024 SETTLE lasts exactly 4 cycles with gate_open=0, then IDLE; requests in SETTLE are neither served nor rejected.
REQ-025 occupancy never exceeds CAPACITY nor underflows below 0; the guards of REQ-018/019 ensure this, and the counter saturates regardless.
REQ-026 full and empty are combinational from occupancy.
REQ-027 Display: free-running scan counter; slot select toggles every SCAN_DIV cycles.
REQ-028 Slot 0: AN=8'b11111110, seg shows occupancy.
REQ-029 Slot 1: AN=8'b11111101, seg shows CAPACITY-occupancy.
REQ-030 Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-031 Any other value drives seg=1111111 (blank); there are no latches.
REQ-032 seg and AN are registered and change on the same edge.

Reset
REQ-033 rst=1 at an edge: FSM=IDLE, gate_open=0, gate_dir=0, reject=0, occupancy=0, timeout and scan counters=0, slot=0, AN=8'b11111110, seg=1000000.
REQ-034 Reset mid-pass closes the gate at the next edge and discards the pending count change.

Structure
REQ-035 Shared package parking_pkg holds the FSM state enum, the 10-entry segment pattern constant, and the SETTLE length constant (4).
REQ-036 One sub-module, seg7_decode: 4-bit value -> 7-bit active-low pattern per REQ-030/031, combinational.
REQ-037 The controller FSM, counters and scan logic live in parking_gate_ctrl.

Verification
REQ-038 Fill: CAPACITY=8; 8 entry requests, each with pass_done -> occupancy 8, full=1, seg on slot 0 = 0000000, slot 1 = 1000000.
REQ-039 Full reject: at occupancy 8, entry_req held 40 cycles -> gate_open stays 0; reject pulses at intervals of 16 cycles or more.
REQ-040 Simultaneous requests: occupancy 3, entry_req and exit_req rise together -> OPEN_OUT, gate_dir=0; after pass_done occupancy=2, and entry is served after SETTLE.
REQ-041 Timeout: GATE_TIMEOUT=10, entry with no pass_done -> gate_open=1 for exactly 10 cycles, then 4 SETTLE cycles; occupancy unchanged.
REQ-042 Reset mid-pass: rst during OPEN_IN with pass_done in the same cycle -> occupancy=0, gate_open=0, AN=8'b11111110 after the edge.
REQ-043 Empty exit: exit_req at occupancy 0 -> reject pulse, no gate motion, occupancy remains 0.
